// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses CS-framed command packets from spi_slave bytes, drives the LED
// register and MISO response bytes. Optional idle timeout: define SPI_CMD_TIMEOUT_EN.
module spi_cmd_decoder #(
    parameter int               LED_W          = 5,
    parameter logic [LED_W-1:0] LED_RST        = '0,
    parameter int               TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_sys_rst,
    input  logic             i_cs,
    input  logic [7:0]       i_rx_byte,
    input  logic             i_rx_valid,
    output logic [LED_W-1:0] o_led,
    output logic [7:0]       o_tx_byte,
    output logic             o_tx_load,
    output logic [7:0]       o_cmd_count,
    output logic             o_err,
    output logic             o_busy,
    output logic [1:0]       o_state
);

    // Handshake: i_rx_valid and o_tx_load are one-cycle strobes with no ready/backpressure;
    // a byte is consumed on the clock edge that samples its strobe, and o_tx_load marks the
    // single cycle in which o_tx_byte takes a new value.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_TOGGLE = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h04;

    state_t           state, state_n;
    logic [1:0]       cs_ff;
    logic             cs_s, cs_d, cs_rise;
    logic             is_toggle, toggle_n;
    logic [LED_W-1:0] led_n;
    logic [7:0]       count_n, tx_n, led_pad;
    logic             load_n, err_set, err_clr, err_n;
    logic             timeout_hit;

    assign cs_s    = cs_ff[1];
    assign cs_rise = cs_s & ~cs_d;

    always_comb begin
        led_pad            = '0;
        led_pad[LED_W-1:0] = o_led;
    end

`ifdef SPI_CMD_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_run;

    assign tmo_run     = ((state == S_DATA) || (state == S_DONE)) && !cs_s;
    assign timeout_hit = tmo_run && !i_rx_valid && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            tmo_cnt <= '0;
        end else if (tmo_run && !i_rx_valid && !timeout_hit) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        led_n    = o_led;
        count_n  = o_cmd_count;
        toggle_n = is_toggle;
        tx_n     = o_tx_byte;
        load_n   = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                // Bytes are parsed here even before cs_s falls, covering synchroniser lag.
                if (i_rx_valid) begin
                    case (i_rx_byte)
                        OP_WRITE: begin
                            state_n  = S_DATA;
                            toggle_n = 1'b0;
                        end
                        OP_TOGGLE: begin
                            state_n  = S_DATA;
                            toggle_n = 1'b1;
                        end
                        OP_READ: begin
                            state_n = S_DONE;
                            tx_n    = led_pad;
                            load_n  = 1'b1;
                            count_n = o_cmd_count + 8'd1;
                        end
                        OP_STATUS: begin
                            state_n = S_DONE;
                            tx_n    = {o_err, o_cmd_count[6:0]};
                            load_n  = 1'b1;
                            count_n = o_cmd_count + 8'd1;
                            err_clr = 1'b1;
                        end
                        default: begin
                            state_n = S_DONE;
                            err_set = 1'b1;
                        end
                    endcase
                end
            end
            S_DATA: begin
                if (i_rx_valid) begin
                    led_n   = is_toggle ? (o_led ^ i_rx_byte[LED_W-1:0]) : i_rx_byte[LED_W-1:0];
                    count_n = o_cmd_count + 8'd1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (i_rx_valid && (o_tx_byte != 8'hFF)) begin
                    tx_n   = 8'hFF;
                    load_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (timeout_hit) begin
            state_n = S_IDLE;
            err_set = 1'b1;
            tx_n    = 8'hFF;
            load_n  = (o_tx_byte != 8'hFF);
        end

        // Frame end wins over whatever the current byte did to the response byte.
        if (cs_rise) begin
            state_n = S_IDLE;
            tx_n    = 8'hFF;
            load_n  = (o_tx_byte != 8'hFF);
            if ((state == S_DATA) && !i_rx_valid) begin
                err_set = 1'b1;
            end
        end

        err_n = err_set ? 1'b1 : (err_clr ? 1'b0 : o_err);
    end

    always_ff @(posedge i_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state       <= S_IDLE;
            cs_ff       <= 2'b11;
            cs_d        <= 1'b1;
            is_toggle   <= 1'b0;
            o_led       <= LED_RST;
            o_tx_byte   <= 8'hFF;
            o_tx_load   <= 1'b0;
            o_cmd_count <= 8'd0;
            o_err       <= 1'b0;
        end else begin
            cs_ff       <= {cs_ff[0], i_cs};
            cs_d        <= cs_s;
            state       <= state_n;
            is_toggle   <= toggle_n;
            o_led       <= led_n;
            o_tx_byte   <= tx_n;
            o_tx_load   <= load_n;
            o_cmd_count <= count_n;
            o_err       <= err_n;
        end
    end

    assign o_busy  = (state != S_IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: table of single-frame commands plus hand-written
// sequences for abort, coincident CS rise, ignored bytes, reset mid-frame, wrap and timeout.
module tb_spi_cmd_decoder;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [4:0] led;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [7:0] cmd_count;
    logic       err;
    logic       busy;
    logic [1:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    spi_cmd_decoder #(
        .LED_W(5),
        .LED_RST(5'h00),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_sys_rst(rst_n),
        .i_cs(cs),
        .i_rx_byte(rx_byte),
        .i_rx_valid(rx_valid),
        .o_led(led),
        .o_tx_byte(tx_byte),
        .o_tx_load(tx_load),
        .o_cmd_count(cmd_count),
        .o_err(err),
        .o_busy(busy),
        .o_state(state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic       has_data;
        logic [7:0] data;
        logic [4:0] exp_led;
        logic [7:0] exp_count;
        logic       exp_err;
        logic [7:0] exp_tx;
        logic       exp_load;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every driver task starts and ends 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic frame_start();
        cs = 1'b0;
        tick(3);
    endtask

    // cs_s rises two edges after cs; the decoder returns to IDLE on the third edge.
    task automatic frame_end(input string name);
        cs = 1'b1;
        tick(3);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_tx"}, {24'd0, tx_byte}, 32'hFF);
    endtask

    initial begin
        vecs[0]  = '{8'h01, 1'b1, 8'h15, 5'h15, 8'd1, 1'b0, 8'hFF, 1'b0};
        vecs[1]  = '{8'h03, 1'b1, 8'h0F, 5'h1A, 8'd2, 1'b0, 8'hFF, 1'b0};
        vecs[2]  = '{8'h02, 1'b0, 8'h00, 5'h1A, 8'd3, 1'b0, 8'h1A, 1'b1};
        vecs[3]  = '{8'h7E, 1'b0, 8'h00, 5'h1A, 8'd3, 1'b1, 8'hFF, 1'b0};
        vecs[4]  = '{8'h04, 1'b0, 8'h00, 5'h1A, 8'd4, 1'b0, 8'h83, 1'b1};
        vecs[5]  = '{8'h02, 1'b0, 8'h00, 5'h1A, 8'd5, 1'b0, 8'h1A, 1'b1};
        vecs[6]  = '{8'h01, 1'b1, 8'hFF, 5'h1F, 8'd6, 1'b0, 8'hFF, 1'b0};
        vecs[7]  = '{8'h03, 1'b1, 8'h1F, 5'h00, 8'd7, 1'b0, 8'hFF, 1'b0};
        vecs[8]  = '{8'h04, 1'b0, 8'h00, 5'h00, 8'd8, 1'b0, 8'h07, 1'b1};
        vecs[9]  = '{8'h00, 1'b0, 8'h00, 5'h00, 8'd8, 1'b1, 8'hFF, 1'b0};
        vecs[10] = '{8'hFF, 1'b0, 8'h00, 5'h00, 8'd8, 1'b1, 8'hFF, 1'b0};

        rst_n    = 1'b0;
        cs       = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        check("rst_led", {27'd0, led}, 32'd0);
        check("rst_tx", {24'd0, tx_byte}, 32'hFF);
        check("rst_load", {31'd0, tx_load}, 32'd0);
        check("rst_count", {24'd0, cmd_count}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            frame_start();
            send_byte(vecs[i].op);
            if (vecs[i].has_data) begin
                send_byte(vecs[i].data);
            end
            check($sformatf("v%0d_led", i), {27'd0, led}, {27'd0, vecs[i].exp_led});
            check($sformatf("v%0d_count", i), {24'd0, cmd_count}, {24'd0, vecs[i].exp_count});
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_tx", i), {24'd0, tx_byte}, {24'd0, vecs[i].exp_tx});
            check($sformatf("v%0d_load", i), {31'd0, tx_load}, {31'd0, vecs[i].exp_load});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            frame_end($sformatf("v%0d_end", i));
        end

        // STATUS with sticky error set, then a WRITE aborted by CS before its data byte.
        frame_start();
        send_byte(8'h04);
        check("st1_tx", {24'd0, tx_byte}, 32'h88);
        check("st1_err", {31'd0, err}, 32'd0);
        frame_end("st1_end");
        frame_start();
        send_byte(8'h01);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        frame_end("abort_end");
        check("abort_led", {27'd0, led}, 32'h00);
        check("abort_err", {31'd0, err}, 32'd1);
        check("abort_count", {24'd0, cmd_count}, 32'd9);

        frame_start();
        send_byte(8'h04);
        check("st2_tx", {24'd0, tx_byte}, 32'h89);
        check("st2_count", {24'd0, cmd_count}, 32'd10);
        frame_end("st2_end");
        check("st2_err", {31'd0, err}, 32'd0);

        // Data byte strobed on the same edge that sees cs_s rise.
        frame_start();
        send_byte(8'h01);
        cs = 1'b1;
        tick(2);
        send_byte(8'h0C);
        check("coin_led", {27'd0, led}, 32'h0C);
        check("coin_count", {24'd0, cmd_count}, 32'd11);
        check("coin_err", {31'd0, err}, 32'd0);
        check("coin_state", {30'd0, state}, 32'd0);
        tick(1);

        // Bytes after a READ are ignored; the first one restores 8'hFF.
        frame_start();
        send_byte(8'h02);
        check("ign_tx0", {24'd0, tx_byte}, 32'h0C);
        check("ign_load0", {31'd0, tx_load}, 32'd1);
        send_byte(8'hAA);
        check("ign_tx1", {24'd0, tx_byte}, 32'hFF);
        check("ign_load1", {31'd0, tx_load}, 32'd1);
        send_byte(8'hBB);
        check("ign_load2", {31'd0, tx_load}, 32'd0);
        check("ign_led", {27'd0, led}, 32'h0C);
        check("ign_count", {24'd0, cmd_count}, 32'd12);
        frame_end("ign_end");
        check("ign_load_end", {31'd0, tx_load}, 32'd0);

`ifdef SPI_CMD_TIMEOUT_EN
        frame_start();
        send_byte(8'h01);
        tick(15);
        check("tmo_busy_pre", {31'd0, busy}, 32'd1);
        tick(1);
        check("tmo_state", {30'd0, state}, 32'd0);
        check("tmo_err", {31'd0, err}, 32'd1);
        send_byte(8'h02);
        check("tmo_reparse_tx", {24'd0, tx_byte}, 32'h0C);
        check("tmo_reparse_count", {24'd0, cmd_count}, 32'd13);
        frame_end("tmo_end");
`else
        frame_start();
        send_byte(8'h01);
        tick(40);
        check("notmo_busy", {31'd0, busy}, 32'd1);
        check("notmo_err", {31'd0, err}, 32'd0);
        frame_end("notmo_end");
        check("notmo_abort_err", {31'd0, err}, 32'd1);
`endif

        // Reset in the middle of a frame.
        frame_start();
        send_byte(8'h03);
        rst_n = 1'b0;
        cs    = 1'b1;
        #1;
        check("mrst_led", {27'd0, led}, 32'd0);
        check("mrst_count", {24'd0, cmd_count}, 32'd0);
        check("mrst_err", {31'd0, err}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_tx", {24'd0, tx_byte}, 32'hFF);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // 256 WRITE frames wrap the command counter.
        for (int i = 0; i < 256; i++) begin
            frame_start();
            send_byte(8'h01);
            send_byte(8'(i));
            if (i == 254) begin
                check("wrap_count_ff", {24'd0, cmd_count}, 32'hFF);
            end
            cs = 1'b1;
            tick(3);
        end
        check("wrap_count", {24'd0, cmd_count}, 32'd0);
        check("wrap_led", {27'd0, led}, 32'h1F);
        check("wrap_err", {31'd0, err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
